mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Shares the single port of a `generic_ram` instance between the instruction-fetch path and the load/store path of the core. It arbitrates requests with data-side priority and a bounded fetch-starvation limit. It also converts sub-word stores into a two-cycle read-modify-write, because the RAM has no byte enables. Read data returns registered, one cycle after grant.

## Interface
- `WIDTH`, 32: RAM word width; must be a multiple of 8.
- `ADDR_W`, 10: word-address width, equal to `$clog2(DEPTH)` of the RAM.
- `MAX_WAIT`, 4: consecutive lost arbitration cycles after which fetch is forced to win; must be ≥ 1.

- `clock`  in  1  single clock; RAM writes on its falling edge.
- `reset`  in  1  synchronous, active-high.
- `if_req`  in  1  fetch read request.
- `if_addr`  in  ADDR_W  fetch word address.
- `if_gnt`  out  1  fetch request accepted this cycle.
- `if_rvalid`  out  1  fetch read data valid.
- `if_rdata`  out  WIDTH  fetch read data.
- `d_req`  in  1  data request.
- `d_we`  in  1  1 = store, 0 = load.
- `d_be`  in  WIDTH/8  store byte enables.
- `d_addr`  in  ADDR_W  data word address.
- `d_wdata`  in  WIDTH  store data.
- `d_gnt`  out  1  data request accepted this cycle.
- `d_rvalid`  out  1  load data valid.
- `d_rdata`  out  WIDTH  load data.
- `ram_we`  out  1  RAM write enable.
- `ram_addr`  out  ADDR_W  RAM address.
- `ram_wdata`  out  WIDTH  RAM write data.
- `ram_rdata`  in  WIDTH  RAM asynchronous read data.

## Operation
- **Handshake**
  - A request is accepted in the cycle where `req` and `gnt` are both high.
  - The requester holds `req`, address and data stable until `gnt` is seen.
  - `gnt` is combinational from state, requests and the wait counter.
  - At most one `gnt` is high per cycle.
- **FSM states:** `ARB` and `RMW_WR`.
- **In `ARB`:**
  - The winner is data if `d_req`, unless `if_req && wait_cnt == MAX_WAIT`, in which case fetch wins.
  - Fetch wins whenever `d_req` is low.
  - The RAM is driven from the winner's address.
- **Load or fetch:** `ram_we=0`. `ram_rdata` is captured into the requester's rdata register at the posedge; `rvalid` is high the next cycle.
- **Full store** (`d_be` all ones): `ram_we=1`, `ram_wdata=d_wdata`. Stay in `ARB`.
- **Partial store** (`d_be` neither zero nor all ones):
  - Grant cycle: RAM read at `d_addr`.
  - The merged word (`d_wdata` bytes where `be=1`, `ram_rdata` bytes otherwise) and the address are registered.
  - Go to `RMW_WR`.
- **Store with `d_be == 0`:** granted, no RAM write, no `rvalid`.
- **In `RMW_WR`:**
  - Drive `ram_we=1` with the registered address and merged word.
  - No grants.
  - Return to `ARB`.
- **Stores** never produce `d_rvalid`.
- **`wait_cnt`** (saturating at `MAX_WAIT`):
  - Increments each cycle that `if_req` is high and `if_gnt` is low, including `RMW_WR` cycles.
  - Clears on `if_gnt` or when `if_req` is low.
- **Reset** (applies at the next posedge, including mid-RMW; a pending merge write is dropped):
  - State becomes `ARB`; `wait_cnt=0`.
  - Both `rvalid` outputs are 0; both rdata registers are 0.
  - While `reset` is high, `if_gnt`, `d_gnt` and `ram_we` are forced to 0.

## Timing
- Read latency is 1: grant in cycle N, `rvalid`/`rdata` in N+1. `rvalid` is a single-cycle pulse per accepted read.
- Throughput is one access per cycle for loads, fetches and full stores.
- A partial store occupies cycles N and N+1; the next grant is at N+2 at the earliest.
- Write-then-read to the same address is coherent:
  - The write commits on the falling edge of its own cycle.
  - A read granted in the following cycle returns the new word.
- An RMW read cycle never asserts `ram_we`; the RMW write cycle never samples `ram_rdata`.

## Test plan
- **Simultaneous requests:** `if_req=1 @0x010`, `d_req=1` load `@0x020` (word 0xDEADBEEF) in one cycle → `d_gnt=1`, `if_gnt=0`; `d_rvalid=1`, `d_rdata=0xDEADBEEF` next cycle; fetch granted the cycle after.
- **Starvation:** `MAX_WAIT=4`; `d_req` loads continuously, `if_req` held → `if_gnt` high in the 5th cycle exactly, then data regains priority.
- **Partial store:** word 0x11223344 @0x005; store `d_be=4'b0010`, `d_wdata=0xAABBCCDD` → 2-cycle occupancy, `ram_we` only in the 2nd cycle, memory holds 0x1122CC44; a load in the next cycle returns 0x1122CC44.
- **Full store then load:** store 0xCAFEF00D `@0x3FF`, then load `@0x3FF` next cycle → `d_rdata=0xCAFEF00D` one cycle after grant; no `d_rvalid` for the store.
- **Zero-enable store:** `d_be=0` → `d_gnt=1`, `ram_we` stays 0, memory unchanged.
- **Reset during RMW:** `reset=1` in the `RMW_WR` cycle → no write commits, all outputs 0; the next request after reset is granted normally.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: fetch, load/store and RAM-port signals for the shared memory port
interface mem_port_arbiter_if #(
  parameter int WIDTH = 32,
  parameter int ADDR_W = 10
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [WIDTH-1:0]  if_rdata;
  logic              d_req;
  logic              d_we;
  logic [WIDTH/8-1:0] d_be;
  logic [ADDR_W-1:0] d_addr;
  logic [WIDTH-1:0]  d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [WIDTH-1:0]  d_rdata;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [WIDTH-1:0]  ram_wdata;
  logic [WIDTH-1:0]  ram_rdata;
  modport master (
    output if_req, if_addr, d_req, d_we, d_be, d_addr, d_wdata, ram_rdata,
    input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata, ram_we, ram_addr, ram_wdata
  );
  modport slave (
    input  if_req, if_addr, d_req, d_we, d_be, d_addr, d_wdata, ram_rdata,
    output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata, ram_we, ram_addr, ram_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one RAM port between fetch and load/store, turning sub-word stores into read-modify-write
module mem_port_arbiter #(
  parameter int WIDTH = 32,
  parameter int ADDR_W = 10,
  parameter int MAX_WAIT = 4
) (
  input logic clock,
  input logic reset,
  mem_port_arbiter_if.slave bus
);
  localparam int NB = WIDTH / 8;
  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);
  typedef enum logic {ARB, RMW_WR} state_t;
  state_t state, state_n;
  logic [WAIT_W-1:0] wait_cnt;
  logic [ADDR_W-1:0] rmw_addr;
  logic [WIDTH-1:0] rmw_data, merged;
  logic d_win, full, partial, rd_d, rmw_start;
  assign full = &bus.d_be;
  assign partial = |bus.d_be && !full;
  assign d_win = bus.d_req && !(bus.if_req && wait_cnt == WAIT_MAX);
  // merge store bytes over the word currently read from RAM
  always_comb begin
    merged = bus.ram_rdata;
    for (int i = 0; i < NB; i++)
      if (bus.d_be[i]) merged[8*i +: 8] = bus.d_wdata[8*i +: 8];
  end
  // grants, RAM port drive and next state
  always_comb begin
    bus.d_gnt = !reset && state == ARB && d_win;
    bus.if_gnt = !reset && state == ARB && bus.if_req && !d_win;
    rd_d = bus.d_gnt && !bus.d_we;
    rmw_start = bus.d_gnt && bus.d_we && partial;
    bus.ram_we = !reset && (state == RMW_WR || (bus.d_gnt && bus.d_we && full));
    bus.ram_addr = state == RMW_WR ? rmw_addr : d_win ? bus.d_addr : bus.if_addr;
    bus.ram_wdata = state == RMW_WR ? rmw_data : bus.d_wdata;
    state_n = rmw_start ? RMW_WR : ARB;
  end
  // state, fetch wait counter and registered read data
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ARB;
      wait_cnt <= '0;
      bus.if_rvalid <= 1'b0;
      bus.d_rvalid <= 1'b0;
      bus.if_rdata <= '0;
      bus.d_rdata <= '0;
    end else begin
      state <= state_n;
      wait_cnt <= (!bus.if_req || bus.if_gnt) ? '0 : wait_cnt == WAIT_MAX ? wait_cnt : wait_cnt + 1'b1;
      bus.if_rvalid <= bus.if_gnt;
      bus.d_rvalid <= rd_d;
      if (bus.if_gnt) bus.if_rdata <= bus.ram_rdata;
      if (rd_d) bus.d_rdata <= bus.ram_rdata;
    end
  end
  // capture address and merged word for the write half of a partial store
  always_ff @(posedge clock) begin
    if (rmw_start) begin
      rmw_addr <= bus.d_addr;
      rmw_data <= merged;
    end
  end
endmodule
